rvc_fetch_aligner: RTL and testbench

- Sits between the read-only I-cache and the decompression unit / IF-ID register.
- Turns the I-cache's 32-bit word stream into one instruction per handshake, 32-bit or 16-bit (RVC), at any halfword-aligned PC.
- Owns the fetch PC and keeps a single-halfword carry buffer so 32-bit instructions may straddle word boundaries.
- Accepts branch/jump redirects from the pipeline.

---
 rtl/rvc_fetch_aligner.sv | 158 +++++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner
//   Takes the I-cache's 32-bit word stream and hands out one instruction
//   per handshake. An instruction is either 32-bit or 16-bit (RVC) and may
//   start at any halfword-aligned PC. The block owns the fetch PC. It keeps
//   one halfword of carry so a 32-bit instruction can straddle two words.
//   Branch/jump redirects from the pipeline restart the stream.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   ICACHE_ren/addr     word read request and word address
//   ICACHE_rdata/stall  fetched word ([15:0] = lower halfword), cache busy
//   redirect_valid/pc   pipeline redirect and its target (bit 0 ignored)
//   instr_ready         downstream accepts the presented instruction
//   instr_valid/instr   output register: raw instruction, RVC zero-extended
//   instr_pc/instr_rvc  PC of the instruction, compressed flag
//   fetch_pc            current fetch PC (debug)
module rvc_fetch_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_rvc,
    output logic [31:0] fetch_pc
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] hold_data_q, hold_data_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_rvc_q, instr_rvc_d;

    logic        out_free;
    logic        hold_rvc;
    logic        word_ok;
    logic        emit;
    logic [31:0] emit_instr;
    logic        unused_pc_bit;

    // Bit 0 of the redirect target is meaningless for halfword-aligned code.
    assign unused_pc_bit = redirect_pc[0];

    assign out_free = !instr_valid_q || instr_ready;
    assign hold_rvc = hold_data_q[1:0] != 2'b11;

    // A compressed instruction sitting in the carry buffer is emitted
    // without touching the cache, so no word is requested for it.
    assign ICACHE_ren = rst_n && out_free && !redirect_valid && !(hold_valid_q && hold_rvc);

    // The carry buffer always holds the upper half of the word at fetch_pc.
    // So while it is occupied, the missing half lives in the following word.
    assign ICACHE_addr = fetch_pc_q[31:2] + {29'd0, hold_valid_q};

    assign word_ok = ICACHE_ren && !ICACHE_stall;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_rvc_d   = instr_rvc_q;
        emit          = 1'b0;
        emit_instr    = 32'd0;

        if (redirect_valid) begin
            fetch_pc_d    = {redirect_pc[31:1], 1'b0};
            hold_valid_d  = 1'b0;
            instr_valid_d = 1'b0;
        end else if (out_free) begin
            if (hold_valid_q && hold_rvc) begin
                // Compressed instruction already buffered.
                emit         = 1'b1;
                emit_instr   = {16'd0, hold_data_q};
                hold_valid_d = 1'b0;
                fetch_pc_d   = fetch_pc_q + 32'd2;
            end else if (hold_valid_q && word_ok) begin
                // Straddling 32-bit instruction completed by the new word.
                // The upper half of that word becomes the next carry.
                emit        = 1'b1;
                emit_instr  = {ICACHE_rdata[15:0], hold_data_q};
                hold_data_d = ICACHE_rdata[31:16];
                fetch_pc_d  = fetch_pc_q + 32'd4;
            end else if (!hold_valid_q && word_ok) begin
                if (!fetch_pc_q[1]) begin
                    if (ICACHE_rdata[1:0] == 2'b11) begin
                        emit       = 1'b1;
                        emit_instr = ICACHE_rdata;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end else begin
                        emit         = 1'b1;
                        emit_instr   = {16'd0, ICACHE_rdata[15:0]};
                        hold_data_d  = ICACHE_rdata[31:16];
                        hold_valid_d = 1'b1;
                        fetch_pc_d   = fetch_pc_q + 32'd2;
                    end
                end else begin
                    if (ICACHE_rdata[17:16] != 2'b11) begin
                        emit       = 1'b1;
                        emit_instr = {16'd0, ICACHE_rdata[31:16]};
                        fetch_pc_d = fetch_pc_q + 32'd2;
                    end else begin
                        // Low half of a 32-bit instruction at an odd halfword:
                        // park it and let the next word finish it.
                        hold_data_d  = ICACHE_rdata[31:16];
                        hold_valid_d = 1'b1;
                    end
                end
            end

            instr_valid_d = emit;
            if (emit) begin
                instr_d     = emit_instr;
                instr_pc_d  = fetch_pc_q;
                instr_rvc_d = emit_instr[1:0] != 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= BOOT_ADDR & 32'hFFFF_FFFE;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= 16'd0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_rvc_q   <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_rvc_q   <= instr_rvc_d;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_rvc   = instr_rvc_q;
    assign fetch_pc    = fetch_pc_q;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Testbench for rvc_fetch_aligner.
//   Memory is a 256-word array indexed by the low address bits. The reference
//   model is the architectural instruction stream: starting at a PC, it reads
//   the halfword there and takes 2 or 4 bytes depending on its low bits. A
//   redirect restarts that stream at the target. Every accepted instruction
//   is compared with the stream. Directed sequences then pin down the cycle
//   timing of the cases of interest.
module tb_rvc_fetch_aligner;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic        ICACHE_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_rvc;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    rvc_fetch_aligner #(.BOOT_ADDR(BOOT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ICACHE_ren     (ICACHE_ren),
        .ICACHE_addr    (ICACHE_addr),
        .ICACHE_rdata   (ICACHE_rdata),
        .ICACHE_stall   (ICACHE_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_rvc      (instr_rvc),
        .fetch_pc       (fetch_pc)
    );

    logic [31:0] mem_arr [0:255];

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;

    logic [31:0] exp_pc;

    // Values sampled one time unit before each rising edge.
    logic        s_ren, s_valid, s_rvc;
    logic [29:0] s_addr;
    logic [31:0] s_instr, s_pc, s_fpc;

    // Output register content that must survive a back-pressured cycle.
    logic        p_hold;
    logic [31:0] p_instr, p_pc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem16(input logic [31:0] a);
        logic [31:0] w;
        w = mem_arr[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] ref_instr(input logic [31:0] a);
        logic [15:0] lo;
        lo = mem16(a);
        if (lo[1:0] == 2'b11) return {mem16(a + 32'd2), lo};
        return {16'd0, lo};
    endfunction

    function automatic logic [31:0] ref_len(input logic [31:0] a);
        logic [15:0] lo;
        lo = mem16(a);
        return (lo[1:0] == 2'b11) ? 32'd4 : 32'd2;
    endfunction

    // One clock cycle: entered at a falling edge, drives inputs, samples
    // outputs just before the rising edge, updates the stream model and
    // returns at the next falling edge.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic stl);
        logic [31:0] ri;
        rst_n          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        ICACHE_stall   = stl;
        #1;
        ICACHE_rdata = stl ? $urandom() : mem_arr[ICACHE_addr[7:0]];
        #3;
        s_ren   = ICACHE_ren;
        s_addr  = ICACHE_addr;
        s_valid = instr_valid;
        s_instr = instr;
        s_pc    = instr_pc;
        s_rvc   = instr_rvc;
        s_fpc   = fetch_pc;

        if (p_hold) begin
            check_eq("stall_valid", {63'd0, s_valid}, 64'd1);
            check_eq("stall_instr", {32'd0, s_instr}, {32'd0, p_instr});
            check_eq("stall_pc", {32'd0, s_pc}, {32'd0, p_pc});
        end

        if (!rst) begin
            check_eq("ren_in_reset", {63'd0, s_ren}, 64'd0);
            exp_pc = BOOT & 32'hFFFF_FFFE;
        end else begin
            if (rv || (s_valid && !rdy))
                check_eq("ren_blocked", {63'd0, s_ren}, 64'd0);
            if (s_valid && rdy) begin
                ri = ref_instr(exp_pc);
                check_eq("sb_instr", {32'd0, s_instr}, {32'd0, ri});
                check_eq("sb_pc", {32'd0, s_pc}, {32'd0, exp_pc});
                check_eq("sb_rvc", {63'd0, s_rvc}, {63'd0, ri[1:0] != 2'b11});
                exp_pc = exp_pc + ref_len(exp_pc);
                n_acc++;
            end
            if (rv) exp_pc = {rpc[31:1], 1'b0};
        end

        p_hold  = rst && !rv && s_valid && !rdy;
        p_instr = s_instr;
        p_pc    = s_pc;
        @(negedge clk);
    endtask

    task automatic go(input logic rdy, input logic stl);
        step(1'b1, 1'b0, 32'd0, rdy, stl);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic fill_mem(input logic [31:0] w);
        for (int i = 0; i < 256; i++) mem_arr[i] = w;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        instr_ready    = 1'b1;
        ICACHE_stall   = 1'b0;
        ICACHE_rdata   = 32'd0;
        exp_pc         = BOOT;
        p_hold         = 1'b0;
        p_instr        = 32'd0;
        p_pc           = 32'd0;
        fill_mem(32'h0001_0001);
        @(negedge clk);

        // Aligned 32-bit instruction, reset state, hit latency.
        mem_arr[0] = 32'h0050_0093;
        do_reset();
        go(1'b1, 1'b0);
        check_eq("rst_valid", {63'd0, s_valid}, 64'd0);
        check_eq("rst_instr", {32'd0, s_instr}, 64'd0);
        check_eq("rst_pc", {32'd0, s_pc}, 64'd0);
        check_eq("rst_rvc", {63'd0, s_rvc}, 64'd0);
        check_eq("rst_fpc", {32'd0, s_fpc}, 64'd0);
        check_eq("t1_ren", {63'd0, s_ren}, 64'd1);
        check_eq("t1_addr0", {34'd0, s_addr}, 64'd0);
        go(1'b1, 1'b0);
        check_eq("t1_valid", {63'd0, s_valid}, 64'd1);
        check_eq("t1_instr", {32'd0, s_instr}, 64'h0050_0093);
        check_eq("t1_pc", {32'd0, s_pc}, 64'd0);
        check_eq("t1_rvc", {63'd0, s_rvc}, 64'd0);
        check_eq("t1_addr1", {34'd0, s_addr}, 64'd1);

        // Two compressed instructions in one word.
        mem_arr[0] = 32'h0001_0001;
        do_reset();
        go(1'b1, 1'b0);
        go(1'b1, 1'b0);
        check_eq("t2_instr0", {32'd0, s_instr}, 64'h1);
        check_eq("t2_pc0", {32'd0, s_pc}, 64'd0);
        check_eq("t2_rvc0", {63'd0, s_rvc}, 64'd1);
        check_eq("t2_ren0", {63'd0, s_ren}, 64'd0);
        go(1'b1, 1'b0);
        check_eq("t2_instr1", {32'd0, s_instr}, 64'h1);
        check_eq("t2_pc1", {32'd0, s_pc}, 64'd2);
        check_eq("t2_addr1", {34'd0, s_addr}, 64'd1);
        check_eq("t2_ren1", {63'd0, s_ren}, 64'd1);

        // Straddle across words 0/1, then a 5-cycle stall, then backpressure.
        mem_arr[0] = 32'h0093_0001;
        mem_arr[1] = 32'h0001_0050;
        mem_arr[2] = 32'h0050_0093;
        do_reset();
        go(1'b1, 1'b0);
        go(1'b1, 1'b0);
        check_eq("t3_pc0", {32'd0, s_pc}, 64'd0);
        check_eq("t3_addr1", {34'd0, s_addr}, 64'd1);
        go(1'b1, 1'b0);
        check_eq("t3_straddle", {32'd0, s_instr}, 64'h0050_0093);
        check_eq("t3_spc", {32'd0, s_pc}, 64'd2);
        check_eq("t3_srvc", {63'd0, s_rvc}, 64'd0);
        check_eq("t3_noren", {63'd0, s_ren}, 64'd0);
        go(1'b1, 1'b1);
        check_eq("t3_hold_instr", {32'd0, s_instr}, 64'h1);
        check_eq("t3_hold_pc", {32'd0, s_pc}, 64'd6);
        for (int i = 0; i < 4; i++) begin
            go(1'b1, 1'b1);
            check_eq("t4_stall_addr", {34'd0, s_addr}, 64'd2);
            check_eq("t4_stall_valid", {63'd0, s_valid}, 64'd0);
        end
        go(1'b1, 1'b0);
        check_eq("t4_release_valid", {63'd0, s_valid}, 64'd0);
        go(1'b0, 1'b0);
        check_eq("t4_after_valid", {63'd0, s_valid}, 64'd1);
        check_eq("t4_after_instr", {32'd0, s_instr}, 64'h0050_0093);
        check_eq("t4_after_pc", {32'd0, s_pc}, 64'd8);
        for (int i = 0; i < 2; i++) begin
            go(1'b0, 1'b0);
            check_eq("t6_bp_fpc", {32'd0, s_fpc}, 64'd12);
        end
        go(1'b1, 1'b0);

        // Redirect while the carry buffer is full; bit 0 of the target ignored.
        mem_arr[0]    = 32'h0001_0001;
        mem_arr[8'h41] = 32'h0001_0093;
        mem_arr[8'h42] = 32'h0000_0050;
        do_reset();
        go(1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0107, 1'b1, 1'b0);
        go(1'b1, 1'b0);
        check_eq("t5_flush_valid", {63'd0, s_valid}, 64'd0);
        check_eq("t5_addr", {34'd0, s_addr}, 64'h41);
        check_eq("t5_fpc", {32'd0, s_fpc}, 64'h106);
        go(1'b1, 1'b0);
        check_eq("t5_rvc_instr", {32'd0, s_instr}, 64'h1);
        check_eq("t5_rvc_pc", {32'd0, s_pc}, 64'h106);
        check_eq("t5_rvc_flag", {63'd0, s_rvc}, 64'd1);
        mem_arr[8'h41] = 32'h0093_0000;
        step(1'b1, 1'b1, 32'h0000_0106, 1'b1, 1'b0);
        go(1'b1, 1'b0);
        check_eq("t5b_addr", {34'd0, s_addr}, 64'h41);
        go(1'b1, 1'b0);
        check_eq("t5b_valid", {63'd0, s_valid}, 64'd0);
        check_eq("t5b_addr2", {34'd0, s_addr}, 64'h42);
        go(1'b1, 1'b0);
        check_eq("t5b_instr", {32'd0, s_instr}, 64'h0050_0093);
        check_eq("t5b_pc", {32'd0, s_pc}, 64'h106);

        // Straddle across the top of the address space.
        mem_arr[8'hFF] = 32'h0093_0000;
        mem_arr[0]     = 32'h0001_0050;
        step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        go(1'b1, 1'b0);
        check_eq("wrap_addr_top", {34'd0, s_addr}, 64'h3FFF_FFFF);
        go(1'b1, 1'b0);
        check_eq("wrap_addr0", {34'd0, s_addr}, 64'd0);
        go(1'b1, 1'b0);
        check_eq("wrap_instr", {32'd0, s_instr}, 64'h0050_0093);
        check_eq("wrap_pc", {32'd0, s_pc}, 64'hFFFF_FFFE);
        check_eq("wrap_fpc", {32'd0, s_fpc}, 64'd2);

        // Reset in the middle of a straddle with a stalled cache.
        step(1'b1, 1'b1, 32'h0000_0106, 1'b1, 1'b0);
        go(1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        go(1'b1, 1'b1);
        check_eq("mid_rst_valid", {63'd0, s_valid}, 64'd0);
        check_eq("mid_rst_fpc", {32'd0, s_fpc}, 64'd0);
        check_eq("mid_rst_addr", {34'd0, s_addr}, 64'd0);

        // Random program, random backpressure/stalls/redirects/resets.
        for (int i = 0; i < 256; i++) begin
            logic [15:0] h0, h1;
            h0 = 16'($urandom());
            h1 = 16'($urandom());
            if ($urandom_range(0, 1) == 0) h0[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) h1[1:0] = 2'b11;
            mem_arr[i] = {h1, h0};
        end
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom(),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0);
        end
        check_eq("rand_progress", {63'd0, n_acc >= 300}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
